// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline: MEM-stage FSM encoding,
// the MEM/WB pipeline record with its bubble value, and default timeout.
package mips_pipe_pkg;

   localparam int DEFAULT_TIMEOUT_CYCLES = 16;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic [31:0] readData;
      logic [31:0] aluResult;
      logic [4:0]  regDest;
      logic        memtoReg;
      logic        regWrite;
   } memwb_t;

   localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_timeout_counter.sv
// Bus watchdog counter: counts consecutive not-ready request cycles and
// flags when the count has reached LIMIT. Generic so an instruction-memory
// port can reuse it.
module mem_timeout_counter #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_terminal
);

   localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

   logic [CNT_W-1:0] r_cnt;

   // Count stalled request cycles; clear wins so a finished access restarts at zero
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_terminal = (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS core: issues loads/stores on a ready-handshaked
// data-memory port, stalls upstream while an access is outstanding, rejects
// misaligned addresses, aborts accesses to a dead memory, and registers MEM/WB.
module mem_access_stage
   import mips_pipe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       EXtoMEM_ALUresult,
   input  logic [31:0]       EXtoMEM_ReadData2,
   input  logic [4:0]        EXtoMEM_RegDest,
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   input  logic              MEM_MemtoReg,
   input  logic              MEM_RegWrite,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ready,
   output logic              mem_stall,
   output logic [31:0]       MEMtoWB_ReadData,
   output logic [31:0]       MEMtoWB_ALUresult,
   output logic [4:0]        MEMtoWB_RegDest,
   output logic              WB_MemtoReg,
   output logic              WB_RegWrite,
   output logic              misalign_pulse,
   output logic              bus_err
);

   mem_state_t r_state;
   mem_state_t w_nextState;
   memwb_t     r_memwb;
   memwb_t     w_memwbNext;
   logic       r_misalign;
   logic       r_busErr;

   logic w_memOp;
   logic w_aligned;
   logic w_terminal;
   logic w_abort;
   logic w_complete;
   logic w_done;
   logic w_readDone;

   assign w_memOp    = MEM_MemRead | MEM_MemWrite;
   assign w_aligned  = (EXtoMEM_ALUresult[1:0] == 2'b00);
   assign w_abort    = (r_state == MEM_WAIT) & w_terminal;
   assign dmem_req   = !rst & w_memOp & w_aligned & !w_abort;
   assign w_complete = dmem_req & dmem_ready;
   // A simultaneous read+write is a write, so only pure reads return data
   assign w_readDone = w_complete & !MEM_MemWrite;
   assign w_done     = !w_memOp | !w_aligned | w_complete | w_abort;
   assign mem_stall  = !rst & !w_done;

   assign dmem_we    = MEM_MemWrite;
   assign dmem_addr  = EXtoMEM_ALUresult[ADDR_W-1:0];
   assign dmem_wdata = EXtoMEM_ReadData2;

   mem_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_complete | w_abort),
      .i_inc      (dmem_req & !dmem_ready),
      .o_terminal (w_terminal)
   );

   // Track whether a request is outstanding waiting for ready
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         MEM_IDLE: if (dmem_req && !dmem_ready) w_nextState = MEM_WAIT;
         MEM_WAIT: if (dmem_ready || w_abort)   w_nextState = MEM_IDLE;
         default:  w_nextState = MEM_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MEM_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Build the MEM/WB record: real result when the stage finishes, bubble while stalled
   always_comb begin
      w_memwbNext = MEMWB_BUBBLE;
      if (w_done) begin
         w_memwbNext.readData  = w_readDone ? dmem_rdata : 32'd0;
         w_memwbNext.aluResult = EXtoMEM_ALUresult;
         w_memwbNext.regDest   = EXtoMEM_RegDest;
         w_memwbNext.memtoReg  = MEM_MemtoReg;
         w_memwbNext.regWrite  = MEM_RegWrite & !(!w_aligned & w_memOp) & !w_abort;
      end
   end

   // MEM/WB pipeline register plus misalign pulse and sticky bus error
   always_ff @(posedge clk) begin
      if (rst) begin
         r_memwb    <= MEMWB_BUBBLE;
         r_misalign <= 1'b0;
         r_busErr   <= 1'b0;
      end else begin
         r_memwb    <= w_memwbNext;
         r_misalign <= w_memOp & !w_aligned;
         r_busErr   <= r_busErr | w_abort;
      end
   end

   assign MEMtoWB_ReadData  = r_memwb.readData;
   assign MEMtoWB_ALUresult = r_memwb.aluResult;
   assign MEMtoWB_RegDest   = r_memwb.regDest;
   assign WB_MemtoReg       = r_memwb.memtoReg;
   assign WB_RegWrite       = r_memwb.regWrite;
   assign misalign_pulse    = r_misalign;
   assign bus_err           = r_busErr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus computes expected outputs
// from a per-instruction behavioural model and queues them; a monitor pops
// and compares one record per cycle.
module tb_mem_access_stage;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] aluIn;
   logic [31:0] wdIn;
   logic [4:0]  destIn;
   logic        rdIn, wrIn, m2rIn, rwIn;
   logic        dmemReq, dmemWe, dmemReady, memStall;
   logic [31:0] dmemAddr, dmemWdata, dmemRdata;
   logic [31:0] wbReadData, wbAlu;
   logic [4:0]  wbDest;
   logic        wbM2r, wbRw, misPulse, busErr;

   always #5 clk = ~clk;

   mem_access_stage #(
      .TIMEOUT_CYCLES (TMO),
      .ADDR_W         (32)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .EXtoMEM_ALUresult (aluIn),
      .EXtoMEM_ReadData2 (wdIn),
      .EXtoMEM_RegDest   (destIn),
      .MEM_MemRead       (rdIn),
      .MEM_MemWrite      (wrIn),
      .MEM_MemtoReg      (m2rIn),
      .MEM_RegWrite      (rwIn),
      .dmem_req          (dmemReq),
      .dmem_we           (dmemWe),
      .dmem_addr         (dmemAddr),
      .dmem_wdata        (dmemWdata),
      .dmem_rdata        (dmemRdata),
      .dmem_ready        (dmemReady),
      .mem_stall         (memStall),
      .MEMtoWB_ReadData  (wbReadData),
      .MEMtoWB_ALUresult (wbAlu),
      .MEMtoWB_RegDest   (wbDest),
      .WB_MemtoReg       (wbM2r),
      .WB_RegWrite       (wbRw),
      .misalign_pulse    (misPulse),
      .bus_err           (busErr)
   );

   typedef struct {
      logic        chkRegs;
      logic        req, stall, we;
      logic [31:0] addr, wdata, rd, alu;
      logic [4:0]  dest;
      logic        m2r, rw, mis, err;
   } exp_t;

   exp_t expQ[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state: what WB should show now, and waits seen by the current instruction
   logic [31:0] mRd = '0, mAlu = '0;
   logic [4:0]  mDest = '0;
   logic        mM2r = 0, mRw = 0, mMis = 0, mErr = 0, mValid = 0;
   int          mWait = 0;
   logic        lastStall = 0;

   task automatic applyStimulus(input logic rstV, input logic rd, input logic wr,
                                input logic m2r, input logic rw, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] dst,
                                input logic rdy, input logic [31:0] rdat);
      exp_t e;
      logic memOp, aligned, abortNow, req, complete, done;
      @(negedge clk);
      rst = rstV; rdIn = rd; wrIn = wr; m2rIn = m2r; rwIn = rw;
      aluIn = alu; wdIn = wd; destIn = dst; dmemReady = rdy; dmemRdata = rdat;
      e.chkRegs = mValid;
      e.rd = mRd; e.alu = mAlu; e.dest = mDest; e.m2r = mM2r; e.rw = mRw;
      e.mis = mMis; e.err = mErr;
      e.we = wr; e.addr = alu; e.wdata = wd;
      if (rstV) begin
         e.req = 0; e.stall = 0;
         mRd = '0; mAlu = '0; mDest = '0; mM2r = 0; mRw = 0; mMis = 0; mErr = 0;
         mWait = 0; mValid = 1; lastStall = 0;
      end else begin
         memOp    = rd | wr;
         aligned  = (alu % 4) == 0;
         abortNow = memOp && aligned && (mWait == TMO);
         req      = memOp && aligned && !abortNow;
         complete = req && rdy;
         done     = !memOp || !aligned || complete || abortNow;
         e.req = req; e.stall = !done;
         if (done) begin
            mRd  = (complete && !wr) ? rdat : 32'd0;
            mAlu = alu; mDest = dst; mM2r = m2r;
            mRw  = rw && !(memOp && !aligned) && !abortNow;
         end else begin
            mRd = '0; mAlu = '0; mDest = '0; mM2r = 0; mRw = 0;
         end
         mMis = memOp && !aligned;
         mErr = mErr || abortNow;
         if (req && !rdy) mWait = mWait + 1;
         else if (complete || abortNow) mWait = 0;
         lastStall = !done;
      end
      expQ.push_back(e);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp("dmem_req", 32'(dmemReq), 32'(e.req));
      cmp("mem_stall", 32'(memStall), 32'(e.stall));
      if (e.req) begin
         cmp("dmem_we", 32'(dmemWe), 32'(e.we));
         cmp("dmem_addr", dmemAddr, e.addr);
         cmp("dmem_wdata", dmemWdata, e.wdata);
      end
      if (e.chkRegs) begin
         cmp("ReadData", wbReadData, e.rd);
         cmp("ALUresult", wbAlu, e.alu);
         cmp("RegDest", 32'(wbDest), 32'(e.dest));
         cmp("MemtoReg", 32'(wbM2r), 32'(e.m2r));
         cmp("RegWrite", 32'(wbRw), 32'(e.rw));
         cmp("misalign_pulse", 32'(misPulse), 32'(e.mis));
         cmp("bus_err", 32'(busErr), 32'(e.err));
      end
   endtask

   // Monitor: one expected record per cycle, sampled well before the next rising edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   task automatic nop();
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
   endtask

   initial begin
      logic        cRd, cWr, cM2r, cRw, cDead, rstV, rdy;
      logic [31:0] cAlu, cWd;
      logic [4:0]  cDst;
      int          kind;
      cRd = 0; cWr = 0; cM2r = 0; cRw = 0; cDead = 0; cAlu = '0; cWd = '0; cDst = '0;
      rst = 1; rdIn = 0; wrIn = 0; m2rIn = 0; rwIn = 0; aluIn = '0; wdIn = '0;
      destIn = '0; dmemReady = 0; dmemRdata = '0;

      applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
      applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
      // zero-wait load
      applyStimulus(0, 1, 0, 1, 1, 32'h10, 32'h0, 5'd7, 1, 32'hDEADBEEF);
      nop();
      // store with three wait cycles
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 0, 1, 0, 0, 32'h24, 32'h12345678, 5'd0, (i == 3), 32'h0);
      nop();
      // misaligned load
      applyStimulus(0, 1, 0, 1, 1, 32'h13, 32'h0, 5'd9, 1, 32'h55);
      nop();
      nop();
      // dead memory: four not-ready cycles then the abort cycle
      for (int i = 0; i < TMO + 1; i++)
         applyStimulus(0, 1, 0, 1, 1, 32'h40, 32'h0, 5'd3, 0, 32'h0);
      nop();
      nop();
      // reset in the middle of a wait, then a clean zero-wait load
      applyStimulus(0, 1, 0, 1, 1, 32'h80, 32'h0, 5'd4, 0, 32'h0);
      applyStimulus(0, 1, 0, 1, 1, 32'h80, 32'h0, 5'd4, 0, 32'h0);
      applyStimulus(1, 1, 0, 1, 1, 32'h80, 32'h0, 5'd4, 0, 32'h0);
      applyStimulus(0, 1, 0, 1, 1, 32'h84, 32'h0, 5'd5, 1, 32'hCAFEF00D);
      // ALU op then back-to-back zero-wait loads
      applyStimulus(0, 0, 0, 0, 1, 32'h0000_1235, 32'h0, 5'd11, 1, 32'hFFFF_FFFF);
      applyStimulus(0, 1, 0, 1, 1, 32'h100, 32'h0, 5'd12, 1, 32'h1111_2222);
      applyStimulus(0, 1, 0, 1, 1, 32'h104, 32'h0, 5'd13, 1, 32'h3333_4444);
      nop();

      // randomized instruction stream; inputs held while the stage stalls
      for (int n = 0; n < 500; n++) begin
         if (!lastStall) begin
            kind = $urandom_range(0, 4);
            cRd  = (kind == 1) || (kind == 3);
            cWr  = (kind == 2) || (kind == 3);
            cM2r = $urandom_range(0, 1);
            cRw  = $urandom_range(0, 1);
            cAlu = $urandom;
            if ($urandom_range(0, 4) != 0) cAlu[1:0] = 2'b00;
            cWd  = $urandom;
            cDst = 5'($urandom);
            cDead = ($urandom_range(0, 9) == 0);
         end
         rstV = ($urandom_range(0, 59) == 0);
         rdy  = cDead ? 1'b0 : ($urandom_range(0, 2) == 0);
         applyStimulus(rstV, cRd, cWr, cM2r, cRw, cAlu, cWd, cDst, rdy, $urandom);
      end
      nop();

      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL queue_drain actual=%0d required=0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage of the 5-stage MIPS core. Consumes the EX/MEM pipeline register outputs and performs the load/store through a ready-handshaked data-memory port.
- Stalls upstream stages while an access is outstanding.
- Registers the MEM/WB pipeline values consumed by write-back.
- Adds a misaligned-address check and a bus-timeout watchdog so a dead memory cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 16: number of consecutive not-ready request cycles before the access is aborted (>=1).
- ADDR_W, 32: data-memory address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- EXtoMEM_ALUresult  in  32  effective address or ALU result
- EXtoMEM_ReadData2  in  32  store data
- EXtoMEM_RegDest  in  5  destination register
- MEM_MemRead  in  1  load
- MEM_MemWrite  in  1  store
- MEM_MemtoReg  in  1  WB select
- MEM_RegWrite  in  1  WB enable
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word address (byte address, [1:0]=0)
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid when dmem_ready
- dmem_ready  in  1  access complete this cycle
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- MEMtoWB_ReadData  out  32  registered load data
- MEMtoWB_ALUresult  out  32  registered ALU result
- MEMtoWB_RegDest  out  5  registered destination
- WB_MemtoReg  out  1  registered
- WB_RegWrite  out  1  registered
- misalign_pulse  out  1  one-cycle flag, registered
- bus_err  out  1  sticky timeout flag

Behaviour:
- Only clk exists; reset is synchronous and active-high (rst sampled on rising clk).
- Definitions:
  - mem_op = MEM_MemRead | MEM_MemWrite.
  - If both MemRead and MemWrite are set, the access is treated as a write.
  - aligned = (EXtoMEM_ALUresult[1:0] == 0).
- FSM states: IDLE (no outstanding access) and WAIT (request outstanding, ready not yet seen).
- dmem_req = !rst & mem_op & aligned & !abort. It is combinational; upstream holds its inputs stable while mem_stall=1.
- Memory-port outputs:
  - dmem_we = MEM_MemWrite.
  - dmem_addr = EXtoMEM_ALUresult.
  - dmem_wdata = EXtoMEM_ReadData2.
  - All three are driven continuously; they are only meaningful while dmem_req=1.
- Handshake and counter:
  - A transfer completes on any cycle with dmem_req & dmem_ready. Zero-wait completion in IDLE is legal.
  - cnt increments on every dmem_req & !dmem_ready cycle and clears on completion, abort, or reset.
  - abort = (state==WAIT) & (cnt==TIMEOUT_CYCLES).
- Transitions:
  - IDLE -> WAIT on dmem_req & !dmem_ready.
  - WAIT -> IDLE on dmem_ready or abort.
- done = !mem_op | !aligned | (dmem_req & dmem_ready) | abort.
- mem_stall = !rst & !done.
- MEM/WB register, updated every clk:
  - If done: load ReadData (dmem_rdata when read completes, else 0), ALUresult, RegDest and MemtoReg.
  - WB_RegWrite = MEM_RegWrite & !( !aligned & mem_op ) & !abort.
  - If !done (stalled): load a bubble (all fields 0, WB_RegWrite=0).
- Misaligned access: no request is issued, and the stage completes in the same cycle with RegWrite suppressed. misalign_pulse=1 for exactly the following cycle.
- Timeout:
  - Exactly TIMEOUT_CYCLES not-ready cycles, then one abort cycle.
  - In the abort cycle: dmem_req=0 and stall releases.
  - bus_err sets on the next edge and holds until rst.
- Back-to-back memory ops: dmem_req may remain high across instructions. Each completion is a separate transfer.
- Reset, including mid-WAIT: state=IDLE, cnt=0, all registered outputs 0, bus_err=0, misalign_pulse=0. While rst=1, dmem_req and mem_stall are forced to 0.
- Latency: zero-wait load produces MEMtoWB_ReadData one clk after the request cycle.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - The state encoding (MEM_IDLE=1'b0, MEM_WAIT=1'b1).
  - The bubble constant.
  - The default TIMEOUT_CYCLES.
- One natural sub-module: mem_timeout_counter (cnt, clear/increment, terminal-count compare), reusable for a future instruction-memory port.
- The MEM/WB register stays inline.

Test Plan:
- Zero-wait load: MemRead=1, MemtoReg=1, RegWrite=1, addr=0x10, ready=1 same cycle, rdata=0xDEADBEEF -> mem_stall=0, next clk MEMtoWB_ReadData=0xDEADBEEF, WB_RegWrite=1, RegDest passed.
- 3-wait store: MemWrite=1, addr=0x24, wdata=0x12345678, ready high on 4th cycle -> dmem_req/addr/wdata stable for 4 cycles, mem_stall=1 for 3 cycles, 3 bubbles with WB_RegWrite=0, then completion; state returns to IDLE.
- Misaligned load: addr=0x13 -> dmem_req never asserts, mem_stall=0, next clk misalign_pulse=1 for one cycle, WB_RegWrite=0.
- Timeout: MemRead, ready held 0, TIMEOUT_CYCLES=4 -> req high 4 cycles, abort on 5th (req=0, stall=0), bus_err=1 from next clk and held, WB_RegWrite=0.
- Reset mid-WAIT: assert rst after 2 wait cycles -> next clk all outputs 0, state IDLE; after rst release a zero-wait load completes normally.
- Non-memory ALU op then back-to-back loads with ready=1: ALU op passes with ReadData=0, WB_RegWrite=1; two consecutive transfers with no stall.
